// File: rtl/adsr_envelope.sv
// adsr_envelope: tick-driven ADSR envelope generator that scales an oscillator sample
module adsr_envelope #(
   parameter bit RETRIGGER_FROM_ZERO = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sample_tick,
   input  logic        gate,
   input  logic [15:0] sample_in,
   input  logic [15:0] attack_rate,
   input  logic [15:0] decay_rate,
   input  logic [15:0] sustain_level,
   input  logic [15:0] release_rate,
   output logic [15:0] sample_out,
   output logic        sample_valid,
   output logic [15:0] env_level,
   output logic [2:0]  env_state,
   output logic        active
);
   typedef enum logic [2:0] {IDLE = 3'd0, ATTACK = 3'd1, DECAY = 3'd2, SUSTAIN = 3'd3, RELEASE = 3'd4} state_t;
   state_t state, state_nxt;
   logic [15:0] level, level_nxt;
   logic [16:0] sum, diff_d, diff_r;
   logic [15:0] prod_hi, prod_unused;
   // The 32-bit signed product holds every possible result, so its top half equals bits [31:16] of the 33-bit form
   assign {prod_hi, prod_unused} = 32'($signed(sample_in)) * 32'($signed({1'b0, level}));
   assign env_level = level;
   assign env_state = state;
   assign active    = state != IDLE;
   // Next state and level for the coming tick; a gate change always wins over the level update
   always_comb begin
      state_nxt = state;
      level_nxt = level;
      sum       = {1'b0, level} + {1'b0, attack_rate};
      diff_d    = {1'b0, level} - {1'b0, decay_rate};
      diff_r    = {1'b0, level} - {1'b0, release_rate};
      case (state)
         IDLE: if (gate) begin
            state_nxt = ATTACK;
            level_nxt = RETRIGGER_FROM_ZERO ? 16'h0 : level;
         end
         ATTACK: if (!gate) state_nxt = RELEASE;
         else if (sum >= 17'h0FFFF || attack_rate == 16'h0) begin
            state_nxt = DECAY;
            level_nxt = 16'hFFFF;
         end else level_nxt = sum[15:0];
         DECAY: if (!gate) state_nxt = RELEASE;
         else if ($signed(diff_d) <= $signed({1'b0, sustain_level}) || decay_rate == 16'h0) begin
            state_nxt = SUSTAIN;
            level_nxt = sustain_level;
         end else level_nxt = diff_d[15:0];
         SUSTAIN: if (!gate) state_nxt = RELEASE;
         else level_nxt = sustain_level;
         RELEASE: if (gate) begin
            state_nxt = ATTACK;
            level_nxt = RETRIGGER_FROM_ZERO ? 16'h0 : level;
         end else if ($signed(diff_r) <= 17'sd0 || release_rate == 16'h0) begin
            state_nxt = IDLE;
            level_nxt = 16'h0;
         end else level_nxt = diff_r[15:0];
         default: begin
            state_nxt = IDLE;
            level_nxt = 16'h0;
         end
      endcase
   end
   // Registers advance only on ticks; sample_out uses the level from before this tick's update
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         level        <= 16'h0;
         sample_out   <= 16'h0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= sample_tick;
         if (sample_tick) begin
            state      <= state_nxt;
            level      <= level_nxt;
            sample_out <= prod_hi;
         end
      end
   end
endmodule

// File: doc/adsr_envelope.md
ADSR_ENVELOPE -- requirements
Module: adsr_envelope

Interface
REQ-001 The block SHALL have parameter RETRIGGER_FROM_ZERO, default 0: when 1, every entry to ATTACK first forces the level to 0; when 0, ATTACK starts from the current level.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 sample_tick  input  1  one-cycle strobe at the audio sample rate; envelope and output advance only on tick cycles.
REQ-005 gate  input  1  note held (1) or released (0); sampled only on tick cycles.
REQ-006 sample_in  input  16  signed oscillator sample from the wavetable stage; sampled on tick cycles.
REQ-007 attack_rate  input  16  unsigned level increment per tick; 0 means instant.
REQ-008 decay_rate  input  16  unsigned level decrement per tick; 0 means instant.
REQ-009 sustain_level  input  16  unsigned sustain target; read live.
REQ-010 release_rate  input  16  unsigned level decrement per tick; 0 means instant.
REQ-011 sample_out  output  16  signed enveloped sample, registered.
REQ-012 sample_valid  output  1  one-cycle pulse marking a new sample_out.
REQ-013 env_level  output  16  unsigned current envelope level, registered.
REQ-014 env_state  output  3  state code: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-015 active  output  1  high whenever env_state is not IDLE.

Function
REQ-016 On non-tick cycles, state, env_level, sample_out and gate history SHALL hold; sample_valid SHALL be 0.
REQ-017 On a tick, sample_out SHALL become bits [31:16] of the signed product sample_in x {1'b0, env_level}, using the pre-update env_level; the product is 33 bits; the shift is arithmetic; saturation is never needed.
REQ-018 sample_valid SHALL be 1 exactly on the cycle after each tick, giving one-cycle latency from tick to sample_out.
REQ-019 The state and env_level updates for a tick SHALL be visible on the cycle after that tick.
REQ-020 In IDLE, env_level is 0. A tick with gate=1 SHALL move the block to ATTACK, with env_level unchanged on that tick.
REQ-021 In ATTACK, each tick SHALL compute level+attack_rate in 17 bits. If the sum is at least 0xFFFF, or attack_rate is 0, the level SHALL become 0xFFFF and the state DECAY. Otherwise the level SHALL become the sum.
REQ-022 In DECAY, each tick SHALL compare level-decay_rate (signed, 17 bits) with sustain_level. If the difference is at most sustain_level, or decay_rate is 0, the level SHALL become sustain_level and the state SUSTAIN. Otherwise the level SHALL become the difference.
REQ-023 In SUSTAIN, each tick SHALL set the level to the current sustain_level, so sustain changes are tracked live.
REQ-024 In RELEASE, each tick SHALL compute level-release_rate. If the result is at most 0, or release_rate is 0, the level SHALL become 0 and the state IDLE. Otherwise the level SHALL become the result.
REQ-025 A tick with gate=0 in ATTACK, DECAY or SUSTAIN SHALL move the block to RELEASE. This transition takes priority over the level update, so the level holds on that tick.
REQ-026 A tick with gate=1 in RELEASE SHALL move the block to ATTACK (retrigger), with the level held, or forced to 0 if RETRIGGER_FROM_ZERO=1.
REQ-027 Gate pulses that start and end between two ticks SHALL be ignored.
REQ-028 Parameter inputs SHALL be read only on tick cycles and MAY change at any time.
REQ-029 If sustain_level is 0xFFFF, DECAY SHALL exit to SUSTAIN on its first tick.

Reset
REQ-030 While reset=1, the block SHALL force env_state to IDLE and set env_level, sample_out, sample_valid and active to 0. A tick coincident with reset is discarded.
REQ-031 Reset mid-envelope SHALL take effect on the next clock edge regardless of state. After reset deasserts, the next tick with gate=1 SHALL enter ATTACK from level 0.

Verification
REQ-032 Attack/decay scenario. Stimulus: attack_rate=0x4000, decay_rate=0x2000, sustain_level=0x8000, gate=1, ticks every 4 clocks. Required response: after successive ticks, env_level = 0 (entering ATTACK), 0x4000, 0x8000, 0xC000, 0xFFFF (DECAY), 0xDFFF, 0xBFFF, 0x9FFF, 0x8000 (SUSTAIN).
REQ-033 Release scenario. Stimulus: from SUSTAIN at 0x8000, gate=0, release_rate=0x3000. Required response: one tick moves to RELEASE with the level held at 0x8000; subsequent ticks give 0x5000, 0x2000, then 0 with IDLE and active=0.
REQ-034 Multiply scenario. Stimulus 1: sample_in=0x4000 with env_level=0x8000 on a tick. Required response: sample_out=0x2000 with sample_valid=1 on the next cycle only. Stimulus 2: sample_in=0x8000 with env_level=0xFFFF. Required response: sample_out=0x8000.
REQ-035 Zero-rate and retrigger scenario. Stimulus 1: attack_rate=0. Required response: the first ATTACK tick gives 0xFFFF. Stimulus 2: gate=1 during RELEASE at level 0x5000. Required response: ATTACK with the level at 0x5000, or at 0 with RETRIGGER_FROM_ZERO=1.
REQ-036 Reset scenario. Stimulus: assert reset during DECAY coincident with a tick. Required response: all outputs 0 and IDLE on the next cycle, and no sample_valid pulse.
